// File: rtl/alarm_fsm.sv
// Car alarm sequencer: arms after the driver leaves, sounds on intrusion,
// and issues interval load requests to an external countdown timer.
module alarm_fsm #(
  parameter logic [3:0] T_ARM_DELAY       = 4'd6,
  parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
  parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic       start_timer,
  output logic [3:0] value,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    DISARMED       = 3'd0,
    WAIT_DRV_OPEN  = 3'd1,
    WAIT_DRV_CLOSE = 3'd2,
    ARM_DELAY      = 3'd3,
    ARMED          = 3'd4,
    TRIGGERED      = 3'd5,
    SOUND_ALARM    = 3'd6,
    SOUND_HOLD     = 3'd7
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] slot_arm;
  logic [3:0] slot_drv;
  logic [3:0] slot_pass;
  logic [3:0] slot_hold;
  logic       start_second;
  logic       any_door;
  logic       qual_expired;
  logic       timed_next;
  logic       entering;
  logic       start_timer_next;
  logic       start_second_next;
  logic [3:0] value_next;
  logic       siren_next;
  logic       status_led_next;

  assign any_door     = door_driver | door_pass;
  // A pulse arriving while we are still requesting a load belongs to an older countdown.
  assign qual_expired = expired & ~start_timer;
  assign fsm_state    = state;

  // Interval slots; writing zero restores the slot's built-in default.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_arm  <= T_ARM_DELAY;
      slot_drv  <= T_DRIVER_DELAY;
      slot_pass <= T_PASSENGER_DELAY;
      slot_hold <= T_ALARM_ON;
    end else if (reprogram) begin
      case (time_param_sel)
        2'd0:    slot_arm  <= (time_value == 4'd0) ? T_ARM_DELAY       : time_value;
        2'd1:    slot_drv  <= (time_value == 4'd0) ? T_DRIVER_DELAY    : time_value;
        2'd2:    slot_pass <= (time_value == 4'd0) ? T_PASSENGER_DELAY : time_value;
        default: slot_hold <= (time_value == 4'd0) ? T_ALARM_ON        : time_value;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= DISARMED;
      start_timer  <= 1'b0;
      start_second <= 1'b0;
      value        <= 4'd0;
      siren        <= 1'b0;
      status_led   <= 1'b0;
    end else begin
      state        <= next_state;
      start_timer  <= start_timer_next;
      start_second <= start_second_next;
      value        <= value_next;
      siren        <= siren_next;
      status_led   <= status_led_next;
    end
  end

  always_comb begin
    next_state        = state;
    timed_next        = 1'b0;
    entering          = 1'b0;
    start_timer_next  = 1'b0;
    start_second_next = 1'b0;
    value_next        = 4'd0;
    siren_next        = 1'b0;
    status_led_next   = 1'b1;

    if (ignition) begin
      next_state = DISARMED;
    end else if (reprogram) begin
      next_state = ARMED;
    end else begin
      case (state)
        DISARMED:       next_state = WAIT_DRV_OPEN;
        WAIT_DRV_OPEN:  if (door_driver)  next_state = WAIT_DRV_CLOSE;
        WAIT_DRV_CLOSE: if (!door_driver) next_state = ARM_DELAY;
        ARM_DELAY: begin
          if (any_door)          next_state = WAIT_DRV_CLOSE;
          else if (qual_expired) next_state = ARMED;
        end
        ARMED:          if (any_door) next_state = TRIGGERED;
        TRIGGERED:      if (qual_expired) next_state = SOUND_ALARM;
        SOUND_ALARM:    if (!any_door) next_state = SOUND_HOLD;
        SOUND_HOLD: begin
          if (any_door)          next_state = SOUND_ALARM;
          else if (qual_expired) next_state = ARMED;
        end
        default:        next_state = DISARMED;
      endcase
    end

    timed_next = (next_state == ARM_DELAY) || (next_state == TRIGGERED) ||
                 (next_state == SOUND_HOLD);
    entering   = timed_next && (next_state != state);

    // The load request spans two cycles so it survives the timer's own DONE cycle.
    if (entering) begin
      start_timer_next  = 1'b1;
      start_second_next = 1'b1;
      case (next_state)
        ARM_DELAY: value_next = slot_arm;
        TRIGGERED: value_next = door_driver ? slot_drv : slot_pass;
        default:   value_next = slot_hold;
      endcase
    end else if (timed_next) begin
      start_timer_next = start_second;
      value_next       = value;
    end

    siren_next = (next_state == SOUND_ALARM) || (next_state == SOUND_HOLD);

    case (next_state)
      DISARMED: status_led_next = 1'b0;
      ARMED:    status_led_next = one_hz_enable;
      default:  status_led_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alarm_fsm.sv
// Scoreboard bench for alarm_fsm: each scenario queues the expected
// outputs per clock and compares them against what the DUT produced.
module tb_alarm_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       ignition;
  logic       door_driver;
  logic       door_pass;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic       start_timer;
  logic [3:0] value;
  logic       siren;
  logic       status_led;
  logic [2:0] fsm_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] got_q[$];
  string      phase;
  int         step_no;

  alarm_fsm dut (
    .clock          (clock),
    .reset          (reset),
    .ignition       (ignition),
    .door_driver    (door_driver),
    .door_pass      (door_pass),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .start_timer    (start_timer),
    .value          (value),
    .siren          (siren),
    .status_led     (status_led),
    .fsm_state      (fsm_state)
  );

  always #5 clock = ~clock;

  // Expected output vector: {state, start_timer, value, siren, status_led}.
  function automatic logic [9:0] ev(input logic [2:0] st, input logic stt,
                                    input logic [3:0] val, input logic sir,
                                    input logic led);
    return {st, stt, val, sir, led};
  endfunction

  task automatic tick(input logic [9:0] e);
    exp_t x;
    x.tag = $sformatf("%s#%0d", phase, step_no);
    x.v   = e;
    exp_q.push_back(x);
    step_no++;
    @(posedge clock);
    #1;
    got_q.push_back({fsm_state, start_timer, value, siren, status_led});
  endtask

  task automatic test_reset;
    reset          = 1'b1;
    ignition       = 1'b1;
    door_driver    = 1'b0;
    door_pass      = 1'b0;
    reprogram      = 1'b0;
    time_param_sel = 2'd0;
    time_value     = 4'd0;
    expired        = 1'b0;
    one_hz_enable  = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({fsm_state, start_timer, value, siren, status_led} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got %b expected %b",
               {fsm_state, start_timer, value, siren, status_led}, 10'd0);
    end
    reset = 1'b0;
  endtask

  task automatic test_arming;
    exp_t x;
    logic [9:0] g;
    phase = "arming"; step_no = 0;
    tick(ev(3'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    ignition = 1'b0;
    tick(ev(3'd1, 1'b0, 4'd0, 1'b0, 1'b1));
    door_driver = 1'b1;
    tick(ev(3'd2, 1'b0, 4'd0, 1'b0, 1'b1));
    door_driver = 1'b0;
    tick(ev(3'd3, 1'b1, 4'd6, 1'b0, 1'b1));
    tick(ev(3'd3, 1'b1, 4'd6, 1'b0, 1'b1));
    tick(ev(3'd3, 1'b0, 4'd6, 1'b0, 1'b1));
    expired = 1'b1; one_hz_enable = 1'b1;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b1));
    expired = 1'b0; one_hz_enable = 1'b0;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    one_hz_enable = 1'b1;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b1));
    one_hz_enable = 1'b0;
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== x.v) begin
        errors++;
        $display("[TB] FAIL %s got %b expected %b (state,start,value,siren,led)", x.tag, g, x.v);
      end
    end
  endtask

  task automatic test_trigger;
    exp_t x;
    logic [9:0] g;
    phase = "trigger"; step_no = 0;
    door_pass = 1'b1;
    tick(ev(3'd5, 1'b1, 4'd15, 1'b0, 1'b1));
    door_pass = 1'b0;
    tick(ev(3'd5, 1'b1, 4'd15, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b0, 4'd15, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    expired = 1'b0;
    tick(ev(3'd7, 1'b1, 4'd10, 1'b1, 1'b1));
    tick(ev(3'd7, 1'b1, 4'd10, 1'b1, 1'b1));
    tick(ev(3'd7, 1'b0, 4'd10, 1'b1, 1'b1));
    expired = 1'b1;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    expired = 1'b0;
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== x.v) begin
        errors++;
        $display("[TB] FAIL %s got %b expected %b (state,start,value,siren,led)", x.tag, g, x.v);
      end
    end
  endtask

  task automatic test_both_doors;
    exp_t x;
    logic [9:0] g;
    phase = "both_doors"; step_no = 0;
    door_driver = 1'b1; door_pass = 1'b1;
    tick(ev(3'd5, 1'b1, 4'd8, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b1, 4'd8, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b0, 4'd8, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    expired = 1'b0;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    door_driver = 1'b0; door_pass = 1'b0;
    tick(ev(3'd7, 1'b1, 4'd10, 1'b1, 1'b1));
    door_driver = 1'b1; ignition = 1'b1;
    tick(ev(3'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    door_driver = 1'b0; ignition = 1'b0;
    reprogram = 1'b1; time_param_sel = 2'd0; time_value = 4'd0;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    reprogram = 1'b0;
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== x.v) begin
        errors++;
        $display("[TB] FAIL %s got %b expected %b (state,start,value,siren,led)", x.tag, g, x.v);
      end
    end
  endtask

  task automatic test_reprogram;
    exp_t x;
    logic [9:0] g;
    phase = "reprogram"; step_no = 0;
    door_pass = 1'b1;
    tick(ev(3'd5, 1'b1, 4'd15, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b1, 4'd15, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b0, 4'd15, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    expired = 1'b0;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    reprogram = 1'b1; time_param_sel = 2'd1; time_value = 4'd3;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    reprogram = 1'b0; door_pass = 1'b0; door_driver = 1'b1;
    tick(ev(3'd5, 1'b1, 4'd3, 1'b0, 1'b1));
    door_driver = 1'b0;
    tick(ev(3'd5, 1'b1, 4'd3, 1'b0, 1'b1));
    reprogram = 1'b1; time_param_sel = 2'd1; time_value = 4'd0;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    reprogram = 1'b0; door_driver = 1'b1;
    tick(ev(3'd5, 1'b1, 4'd8, 1'b0, 1'b1));
    door_driver = 1'b0;
    reprogram = 1'b1; time_param_sel = 2'd3; time_value = 4'd5;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    reprogram = 1'b0; door_pass = 1'b1;
    tick(ev(3'd5, 1'b1, 4'd15, 1'b0, 1'b1));
    door_pass = 1'b0;
    tick(ev(3'd5, 1'b1, 4'd15, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b0, 4'd15, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    expired = 1'b0;
    tick(ev(3'd7, 1'b1, 4'd5, 1'b1, 1'b1));
    reprogram = 1'b1; time_param_sel = 2'd0; time_value = 4'd2;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    reprogram = 1'b0; time_value = 4'd0;
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== x.v) begin
        errors++;
        $display("[TB] FAIL %s got %b expected %b (state,start,value,siren,led)", x.tag, g, x.v);
      end
    end
  endtask

  task automatic test_arm_delay_edges;
    exp_t x;
    logic [9:0] g;
    phase = "arm_delay_edges"; step_no = 0;
    ignition = 1'b1;
    tick(ev(3'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    ignition = 1'b0;
    tick(ev(3'd1, 1'b0, 4'd0, 1'b0, 1'b1));
    door_driver = 1'b1;
    tick(ev(3'd2, 1'b0, 4'd0, 1'b0, 1'b1));
    door_driver = 1'b0;
    tick(ev(3'd3, 1'b1, 4'd2, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd3, 1'b1, 4'd2, 1'b0, 1'b1));
    expired = 1'b0;
    tick(ev(3'd3, 1'b0, 4'd2, 1'b0, 1'b1));
    expired = 1'b1; door_pass = 1'b1;
    tick(ev(3'd2, 1'b0, 4'd0, 1'b0, 1'b1));
    expired = 1'b0; door_pass = 1'b0;
    tick(ev(3'd3, 1'b1, 4'd2, 1'b0, 1'b1));
    tick(ev(3'd3, 1'b1, 4'd2, 1'b0, 1'b1));
    tick(ev(3'd3, 1'b0, 4'd2, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    expired = 1'b0;
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== x.v) begin
        errors++;
        $display("[TB] FAIL %s got %b expected %b (state,start,value,siren,led)", x.tag, g, x.v);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t x;
    logic [9:0] g;
    phase = "async_reset"; step_no = 0;
    door_pass = 1'b1;
    tick(ev(3'd5, 1'b1, 4'd15, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b1, 4'd15, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b0, 4'd15, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    expired = 1'b0;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({fsm_state, start_timer, value, siren, status_led} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_immediate got %b expected %b",
               {fsm_state, start_timer, value, siren, status_led}, 10'd0);
    end
    @(posedge clock);
    #1;
    checks++;
    if ({fsm_state, start_timer, value, siren, status_led} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_held got %b expected %b",
               {fsm_state, start_timer, value, siren, status_led}, 10'd0);
    end
    door_pass = 1'b0;
    reset = 1'b0;
    tick(ev(3'd1, 1'b0, 4'd0, 1'b0, 1'b1));
    door_driver = 1'b1;
    tick(ev(3'd2, 1'b0, 4'd0, 1'b0, 1'b1));
    door_driver = 1'b0;
    tick(ev(3'd3, 1'b1, 4'd6, 1'b0, 1'b1));
    tick(ev(3'd3, 1'b1, 4'd6, 1'b0, 1'b1));
    tick(ev(3'd3, 1'b0, 4'd6, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd4, 1'b0, 4'd0, 1'b0, 1'b0));
    expired = 1'b0; door_driver = 1'b1;
    tick(ev(3'd5, 1'b1, 4'd8, 1'b0, 1'b1));
    door_driver = 1'b0;
    tick(ev(3'd5, 1'b1, 4'd8, 1'b0, 1'b1));
    tick(ev(3'd5, 1'b0, 4'd8, 1'b0, 1'b1));
    expired = 1'b1;
    tick(ev(3'd6, 1'b0, 4'd0, 1'b1, 1'b1));
    expired = 1'b0;
    tick(ev(3'd7, 1'b1, 4'd10, 1'b1, 1'b1));
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== x.v) begin
        errors++;
        $display("[TB] FAIL %s got %b expected %b (state,start,value,siren,led)", x.tag, g, x.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arming();
    test_trigger();
    test_both_doors();
    test_reprogram();
    test_arm_delay_edges();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_fsm.md
ALARM_FSM -- requirements
Module: alarm_fsm

Interface
- REQ-001: Parameter T_ARM_DELAY, default 4'd6, arming delay in seconds (slot 0).
- REQ-002: Parameter T_DRIVER_DELAY, default 4'd8, driver-door entry delay in seconds (slot 1).
- REQ-003: Parameter T_PASSENGER_DELAY, default 4'd15, passenger-door entry delay in seconds (slot 2).
- REQ-004: Parameter T_ALARM_ON, default 4'd10, siren hold time after doors close, in seconds (slot 3).
- REQ-005: clock  in  1  sole clock; all state updates on its rising edge.
- REQ-006: reset  in  1  asynchronous, active-high reset.
- REQ-007: ignition  in  1  1 = key on.
- REQ-008: door_driver  in  1  1 = driver door open.
- REQ-009: door_pass  in  1  1 = passenger door open.
- REQ-010: reprogram  in  1  1 = write time_value into slot time_param_sel this cycle.
- REQ-011: time_param_sel  in  2  parameter slot select, 0..3 per REQ-001..004.
- REQ-012: time_value  in  4  new interval in seconds; 0 = restore that slot's default.
- REQ-013: expired  in  1  one-cycle done pulse from the countdown timer.
- REQ-014: one_hz_enable  in  1  1 Hz square wave from the timer, used for LED blink.
- REQ-015: start_timer  out  1  timer load request, registered.
- REQ-016: value  out  4  interval for the timer, registered, valid whenever start_timer=1.
- REQ-017: siren  out  1  1 = siren on.
- REQ-018: status_led  out  1  armed/status indicator.
- REQ-019: fsm_state  out  3  current state code for the display.

Function
- REQ-020: State codes SHALL be DISARMED=0, WAIT_DRV_OPEN=1, WAIT_DRV_CLOSE=2, ARM_DELAY=3, ARMED=4, TRIGGERED=5, SOUND_ALARM=6, SOUND_HOLD=7.
- REQ-021: Transition priority SHALL be: reset, then ignition=1 (to DISARMED from any state), then reprogram=1 (to ARMED), then per-state rules.
- REQ-022: DISARMED->WAIT_DRV_OPEN on ignition=0; WAIT_DRV_OPEN->WAIT_DRV_CLOSE on door_driver=1; WAIT_DRV_CLOSE->ARM_DELAY on door_driver=0.
- REQ-023: ARM_DELAY->WAIT_DRV_CLOSE on any door open, taking precedence over expired; ARM_DELAY->ARMED on qualified expired.
- REQ-024: ARMED->TRIGGERED on any door open.
- REQ-025: TRIGGERED->SOUND_ALARM on qualified expired; door activity in TRIGGERED is ignored.
- REQ-026: SOUND_ALARM->SOUND_HOLD when both doors are closed; SOUND_HOLD->SOUND_ALARM on any door open (precedence over expired); SOUND_HOLD->ARMED on qualified expired.
- REQ-027: start_timer SHALL be 1 for exactly the first two cycles of each entry into ARM_DELAY, TRIGGERED or SOUND_HOLD, and 0 otherwise.
- REQ-028: Two cycles are required because the timer ignores a request issued in its DONE cycle.
- REQ-029: Qualified expired SHALL be expired=1 while start_timer=0; expired is ignored in all other states and cycles, which discards stale pulses.
- REQ-030: value SHALL be slot 0 in ARM_DELAY, slot 3 in SOUND_HOLD, and 0 in untimed states.
- REQ-031: In TRIGGERED, value SHALL be slot 1 if door_driver=1 on the entry cycle, else slot 2; driver wins if both doors open. value is latched for the whole state.
- REQ-032: siren SHALL be 1 exactly in SOUND_ALARM and SOUND_HOLD.
- REQ-033: status_led SHALL be 0 in DISARMED, equal one_hz_enable in ARMED, and 1 in all other states.
- REQ-034: Parameter slot writes take effect on the next edge; a write during a running countdown does not alter the value already latched.
- REQ-035: All state and output changes SHALL appear one clock after the sampled input condition.

Reset
- REQ-036: On reset: state=DISARMED, start_timer=0, value=0, siren=0, status_led=0, and slots 0..3 reload their parameter defaults.
- REQ-037: Reset asserted mid-countdown or mid-alarm SHALL take effect immediately and asynchronously, with no further start_timer pulse.

Verification
- V1: ignition 1->0, driver door open then close -> states 0,1,2,3; start_timer high 2 cycles with value=6; expired pulse -> ARMED, LED follows one_hz_enable.
- V2: ARMED, door_pass=1 -> TRIGGERED, value=15; expired -> SOUND_ALARM, siren=1; doors close -> SOUND_HOLD, value=10; expired -> ARMED, siren=0.
- V3: ARMED, both doors open on the same cycle -> value=8; driver door held open with ignition=1 in SOUND_HOLD -> DISARMED, siren=0 next cycle.
- V4: reprogram with sel=1, time_value=3 in SOUND_ALARM -> ARMED; next trigger via driver door -> value=3; then reprogram with sel=1, time_value=0 -> value=8 on the next trigger.
- V5: expired=1 during the first start_timer cycle of ARM_DELAY -> state stays ARM_DELAY; door reopened on the same cycle as expired in ARM_DELAY -> WAIT_DRV_CLOSE.
- V6: reset asserted mid-SOUND_ALARM between clock edges -> siren=0 and fsm_state=0 immediately, with slots at their defaults.
